// File: rtl/nlz_share_pkg.sv
// nlz_share_pkg: shared widths and types for the shared NLZ scheduler
package nlz_share_pkg;
  localparam int NLZ_W = 32;
  localparam int CNT_W = 6;
  localparam int ID_MAX_W = 4;
  typedef logic [CNT_W-1:0] nlz_cnt_t;
  typedef struct packed {
    logic [NLZ_W-1:0]    operand;
    logic [ID_MAX_W-1:0] id;
  } nlz_req_t;
endpackage

// File: rtl/nlz32_comb.sv
// nlz32_comb: combinational 32-bit leading-zero counter, 32 for a zero input
module nlz32_comb
  import nlz_share_pkg::*;
(
  input  logic [NLZ_W-1:0] in,
  output nlz_cnt_t         out
);
  always_comb begin
    out = CNT_W'(NLZ_W);
    for (int i = 0; i < NLZ_W; i++)
      if (in[i]) out = CNT_W'(NLZ_W - 1 - i);
  end
endmodule

// File: rtl/nlz_share_sched.sv
// nlz_share_sched: round-robin share of one NLZ unit across NUM_REQ requesters
// Optional NLZ_SHARE_ZERO_FLAG_EN adds rsp_zero and saturates rsp_count to 31.
module nlz_share_sched
  import nlz_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output nlz_cnt_t                  rsp_count,
  output logic                      busy
`ifdef NLZ_SHARE_ZERO_FLAG_EN
  , output logic                    rsp_zero
`endif
);
  localparam logic [ID_W:0]   NR   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);
  logic [ID_W-1:0] rr_ptr, gnt_idx;
  logic [ID_W:0]   cand;
  logic            found, s0_vld, s1_vld, s0_load, s1_load, xfer;
  nlz_req_t        s0;
  nlz_cnt_t        cnt;
  // Walk downward so the candidate nearest rr_ptr is the last one written.
  always_comb begin
    gnt_idx = '0;
    found = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      cand = cand >= NR ? cand - NR : cand;
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt_idx = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign s1_load   = ~s1_vld | rsp_ready;
  assign s0_load   = ~s0_vld | s1_load;
  assign xfer      = found & s0_load;
  assign req_ready = xfer ? NUM_REQ'(1) << gnt_idx : '0;
  assign rsp_valid = s1_vld;
  assign busy      = s0_vld | s1_vld;
  nlz32_comb u_nlz (.in(s0.operand), .out(cnt));
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld <= 1'b0;
      s1_vld <= 1'b0;
      rr_ptr <= '0;
      rsp_id <= '0;
      rsp_count <= '0;
`ifdef NLZ_SHARE_ZERO_FLAG_EN
      rsp_zero <= 1'b0;
`endif
    end else begin
      if (s0_load) s0_vld <= found;
      if (xfer) begin
        s0.operand <= req_data[gnt_idx*DATA_W +: DATA_W];
        s0.id <= ID_MAX_W'(gnt_idx);
        rr_ptr <= gnt_idx == LAST ? '0 : gnt_idx + 1'b1;
      end
      if (s1_load) s1_vld <= s0_vld;
      if (s1_load && s0_vld) begin
        rsp_id <= s0.id[ID_W-1:0];
`ifdef NLZ_SHARE_ZERO_FLAG_EN
        rsp_count <= cnt[5] ? nlz_cnt_t'(31) : cnt;
        rsp_zero <= cnt[5];
`else
        rsp_count <= cnt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_nlz_share_sched.sv
// tb_nlz_share_sched: scoreboard bench for nlz_share_sched
// Honours NLZ_SHARE_ZERO_FLAG_EN when the design is built with it.
module tb_nlz_share_sched;
  typedef struct {
    int         id;
    logic [5:0] cnt;
    logic       zero;
  } exp_t;
  logic         clk = 0, rst = 1, rsp_ready = 0;
  logic [3:0]   req_valid = 0;
  logic [127:0] req_data = 0;
  logic [3:0]   req_ready;
  logic         rsp_valid, busy;
  logic [1:0]   rsp_id;
  logic [5:0]   rsp_count;
  logic         rsp_zero;
  int           n_cmp = 0, n_err = 0;
  exp_t         q[$];
  int           glog[$];
  logic         m0 = 0, m1 = 0, can, s1l, s0l;
  int           m_ptr = 0, exp_g, j;
  logic [3:0]   exp_rdy;
  exp_t         e;
  nlz_share_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
`ifdef NLZ_SHARE_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );
`ifndef NLZ_SHARE_ZERO_FLAG_EN
  assign rsp_zero = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [5:0] ref_nlz(input logic [31:0] v);
    int n = 0;
    while (n < 32 && !v[31-n]) n++;
`ifdef NLZ_SHARE_ZERO_FLAG_EN
    if (n == 32) n = 31;
`endif
    return 6'(n);
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_g = -1;
    if (!rst) begin
      can = !(m0 && m1 && !rsp_ready);
      for (int k = 3; k >= 0; k--) begin
        j = (m_ptr + k) % 4;
        if (can && req_valid[j]) exp_g = j;
      end
      exp_rdy = exp_g >= 0 ? 4'(1 << exp_g) : 4'd0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    end
    chk("busy", 32'(busy), 32'(m0 | m1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m1));
    if (rsp_valid && q.size() > 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_count", 32'(rsp_count), 32'(q[0].cnt));
`ifdef NLZ_SHARE_ZERO_FLAG_EN
      chk("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
`endif
    end
    if (rst) begin
      m0 = 0; m1 = 0; m_ptr = 0; q.delete();
    end else begin
      if (rsp_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
      s1l = !m1 || rsp_ready;
      s0l = !m0 || s1l;
      if (s1l) m1 = m0;
      if (s0l) m0 = exp_g >= 0;
      if (exp_g >= 0) begin
        e.id = exp_g;
        e.cnt = ref_nlz(req_data[exp_g*32 +: 32]);
        e.zero = req_data[exp_g*32 +: 32] == 0;
        q.push_back(e);
        glog.push_back(exp_g);
        m_ptr = (exp_g + 1) % 4;
      end
    end
  end
  initial begin
    logic [31:0] bops [4];
    logic [5:0]  bcnt [4];
    int          g2 [6];
    int          g6 [3];
    bops = '{32'h0, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
`ifdef NLZ_SHARE_ZERO_FLAG_EN
    bcnt = '{6'd31, 6'd0, 6'd31, 6'd0};
`else
    bcnt = '{6'd32, 6'd0, 6'd31, 6'd0};
`endif
    g2 = '{0, 1, 2, 3, 0, 1};
    g6 = '{1, 0, 1};
    cyc(2);
    rst = 0;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_count", 32'(rsp_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    // single request
    rsp_ready = 1; req_valid = 4'b0001; req_data[31:0] = 32'h0000_0F00;
    cyc(1);
    req_valid = 0;
    chk("t1_latency", 32'(rsp_valid), 0);
    cyc(1);
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_count", 32'(rsp_count), 20);
    cyc(2);
    rst = 1;
    cyc(1);
    rst = 0;
    // round-robin with all requesters active
    glog.delete();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h1 << (i * 7 + 2);
    req_valid = 4'b1111;
    cyc(8);
    req_valid = 0;
    cyc(3);
    chk("t2_grants", 32'(glog.size()), 8);
    for (int i = 0; i < 6; i++) chk("t2_order", 32'(glog[i]), 32'(g2[i]));
    // backpressure
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h0001_0000 >> i;
    req_valid = 4'b1111;
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("t3_hold_id", 32'(rsp_id), 0);
      chk("t3_hold_count", 32'(rsp_count), 15);
      chk("t3_ready_low", 32'(req_ready), 0);
    end
    req_valid = 0; rsp_ready = 1;
    cyc(4);
    chk("t3_drained", 32'(q.size()), 0);
    // boundary operands
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0100; req_data[64 +: 32] = bops[i];
      cyc(1);
      req_valid = 0;
      cyc(1);
      chk("t4_count", 32'(rsp_count), 32'(bcnt[i]));
`ifdef NLZ_SHARE_ZERO_FLAG_EN
      chk("t4_zero", 32'(rsp_zero), 32'(i == 0));
`endif
    end
    cyc(2);
    // reset with both stages full
    rsp_ready = 0; req_valid = 4'b1111;
    cyc(3);
    rst = 1; req_valid = 4'b1010;
    cyc(1);
    rst = 0;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    glog.delete();
    cyc(1);
    req_valid = 0; rsp_ready = 1;
    cyc(1);
    // pointer at 2 with only 0 and 1 requesting
    req_valid = 4'b0011;
    cyc(2);
    req_valid = 0;
    cyc(4);
    chk("t6_grants", 32'(glog.size()), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) chk("t6_order", 32'(glog[i]), 32'(g6[i]));
    chk("final_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
